// File: rtl/finite_state_machine_pkg.sv
// Shared definitions for the display-interface sequencer: opcodes, FSM states
// and instruction field positions.
package finite_state_machine_pkg;

  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_DATA  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  // Instruction layout: {op[1:0], d[7:0]}
  localparam int OP_HI = 9;
  localparam int OP_LO = 8;
  localparam int D_HI  = 7;
  localparam int D_LO  = 0;

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

endpackage

// File: rtl/delay_counter.sv
// Delay counter: a load starts a stall of loadVal clks; pcEn is low while
// the count is non-zero. lastCycle flags the clk on which the count hits 0.
module delay_counter #(
  parameter int DELAY_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   delayEn,
  input  logic [DELAY_WIDTH-1:0] loadVal,
  output logic                   pcEn,
  output logic                   lastCycle
);

  logic [DELAY_WIDTH-1:0] r_count;

  // Load on delayEn (reload if already counting), otherwise count down to 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_count <= '0;
    else if (delayEn)          r_count <= loadVal;
    else if (r_count != '0)    r_count <= r_count - 1'b1;
  end

  assign pcEn      = (r_count == '0);
  assign lastCycle = (r_count == DELAY_WIDTH'(1)) && !delayEn;

endmodule

// File: rtl/finite_state_machine.sv
// Instruction-driven SPI display sequencer: instruction memory, per-tick
// decoder into cs/dc/payload, and a delay stall for the program counter.
module finite_state_machine
  import finite_state_machine_pkg::*;
#(
  parameter int MEM_BITS    = 10,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int DELAY_UNIT  = 16,
  parameter int DELAY_WIDTH = 24,
  parameter     INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclkPosEdge,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [MEM_BITS-1:0]   dataIn,
  output logic [MEM_BITS-1:0]   dataOut,
  output logic                  cs,
  output logic                  dc,
  output logic                  delayEn,
  output logic [7:0]            parallelData,
  output logic                  pcEn
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [MEM_BITS-1:0] r_mem [0:DEPTH-1];

  state_t     r_state, w_nextState;
  logic       r_cs, r_dc, r_delayEn;
  logic [7:0] r_pd, r_delayD;
  logic       w_cs, w_dc, w_delayEn;
  logic [7:0] w_pd, w_delayD;
  logic [1:0] w_op;
  logic [7:0] w_d;
  logic       w_last;
  logic [DELAY_WIDTH-1:0] w_load;

  // Start from all-zero contents
  initial for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;

  // Synchronous write; upper address bits ignored so addresses wrap
  always_ff @(posedge clk) begin
    if (writeEnable) r_mem[addr[DEPTH_LOG2-1:0]] <= dataIn;
  end

  assign dataOut = r_mem[addr[DEPTH_LOG2-1:0]];
  assign w_op    = dataOut[OP_HI:OP_LO];
  assign w_d     = dataOut[D_HI:D_LO];

  // State and registered decode outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_cs      <= 1'b1;
      r_dc      <= 1'b0;
      r_pd      <= 8'h00;
      r_delayEn <= 1'b0;
      r_delayD  <= 8'h00;
    end else begin
      r_state   <= w_nextState;
      r_cs      <= w_cs;
      r_dc      <= w_dc;
      r_pd      <= w_pd;
      r_delayEn <= w_delayEn;
      r_delayD  <= w_delayD;
    end
  end

  // Next state: a non-zero delay parks the FSM until the counter drains
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN:  if (sclkPosEdge && w_op == OP_DELAY && w_d != 8'h00) w_nextState = WAIT;
      WAIT: if (w_last) w_nextState = RUN;
      default: w_nextState = RUN;
    endcase
  end

  // Decode: only on a tick in RUN; everything else holds, delayEn is a pulse
  always_comb begin
    w_cs      = r_cs;
    w_dc      = r_dc;
    w_pd      = r_pd;
    w_delayD  = r_delayD;
    w_delayEn = 1'b0;
    if (r_state == RUN && sclkPosEdge) begin
      case (w_op)
        OP_CMD:   begin w_cs = 1'b0; w_dc = 1'b0; w_pd = w_d; end
        OP_DATA:  begin w_cs = 1'b0; w_dc = 1'b1; w_pd = w_d; end
        OP_DELAY: begin
          w_cs      = 1'b1;
          w_delayEn = (w_d != 8'h00);
          w_delayD  = w_d;
        end
        default:  w_cs = 1'b1;
      endcase
    end
  end

  // Length latched with the decode so a moving addr cannot corrupt it
  assign w_load = DELAY_WIDTH'(r_delayD) * DELAY_WIDTH'(DELAY_UNIT);

  delay_counter #(.DELAY_WIDTH(DELAY_WIDTH)) u_delay (
    .clk       (clk),
    .reset     (reset),
    .delayEn   (r_delayEn),
    .loadVal   (w_load),
    .pcEn      (pcEn),
    .lastCycle (w_last)
  );

  assign cs           = r_cs;
  assign dc           = r_dc;
  assign parallelData = r_pd;
  assign delayEn      = r_delayEn;

endmodule

// File: tb/tb_finite_state_machine.sv
// Self-checking bench for the display sequencer: table-driven decode vectors
// through a scoreboard queue plus hand-written delay/reset/write sequences.
module tb_finite_state_machine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclkPosEdge = 1'b0;
  logic        writeEnable = 1'b0;
  logic [15:0] addr = '0;
  logic [9:0]  dataIn = '0;
  logic [9:0]  dataOut;
  logic        cs, dc, delayEn, pcEn;
  logic [7:0]  parallelData;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [9:0]  w;
    logic        cs, dc, de;
    logic [7:0]  pd;
  } vec_t;

  typedef struct {
    int         idx;
    logic       cs, dc, de;
    logic [7:0] pd;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  finite_state_machine dut (
    .clk(clk), .reset(reset), .sclkPosEdge(sclkPosEdge),
    .writeEnable(writeEnable), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut), .cs(cs), .dc(dc), .delayEn(delayEn),
    .parallelData(parallelData), .pcEn(pcEn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [9:0] w);
    @(negedge clk);
    addr = a; dataIn = w; writeEnable = 1'b1;
    @(negedge clk);
    writeEnable = 1'b0;
  endtask

  task automatic tick(input logic [15:0] a);
    @(negedge clk);
    addr = a; sclkPosEdge = 1'b1;
    @(posedge clk);
    #1 sclkPosEdge = 1'b0;
  endtask

  task automatic chk_outs(input string nm, input logic c, input logic d,
                          input logic e, input logic [7:0] p);
    chk({nm, ".cs"}, 32'(cs), 32'(c));
    chk({nm, ".dc"}, 32'(dc), 32'(d));
    chk({nm, ".delayEn"}, 32'(delayEn), 32'(e));
    chk({nm, ".pd"}, 32'(parallelData), 32'(p));
  endtask

  initial begin
    int low_cnt;
    logic [7:0] hold_pd;
    logic       hold_dc;
    exp_t e;

    vecs[0] = '{16'd10, 10'h0AE, 1'b0, 1'b0, 1'b0, 8'hAE};
    vecs[1] = '{16'd11, 10'h1A5, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{16'd12, 10'h300, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[3] = '{16'd13, 10'h012, 1'b0, 1'b0, 1'b0, 8'h12};
    vecs[4] = '{16'd14, 10'h200, 1'b1, 1'b0, 1'b0, 8'h12};
    vecs[5] = '{16'd15, 10'h155, 1'b0, 1'b1, 1'b0, 8'h55};
    vecs[6] = '{16'd16, 10'h3FF, 1'b1, 1'b1, 1'b0, 8'h55};

    // Reset state
    #12;
    chk_outs("reset", 1'b1, 1'b0, 1'b0, 8'h00);
    chk("reset.pcEn", 32'(pcEn), 32'd1);
    @(negedge clk) reset = 1'b1;

    // Memory write/read and address wrap
    wr(16'd3, 10'h0AE);
    addr = 16'd3;       #1 chk("rd.addr3", 32'(dataOut), 32'h0AE);
    addr = 16'h0403;    #1 chk("rd.wrap", 32'(dataOut), 32'h0AE);

    foreach (vecs[i]) wr(vecs[i].a, vecs[i].w);
    wr(16'd20, 10'h203);
    wr(16'd30, 10'h0AA);

    // Table-driven decode through the scoreboard
    foreach (vecs[i]) begin
      sb.push_back('{i, vecs[i].cs, vecs[i].dc, vecs[i].de, vecs[i].pd});
      tick(vecs[i].a);
      e = sb.pop_front();
      chk_outs($sformatf("vec%0d", e.idx), e.cs, e.dc, e.de, e.pd);
      chk($sformatf("vec%0d.pcEn", e.idx), 32'(pcEn), 32'd1);
    end

    // Delay of 3 units: pulse, then pcEn low for exactly 48 clks
    hold_dc = dc; hold_pd = parallelData;
    tick(16'd20);
    chk_outs("dly.pulse", 1'b1, hold_dc, 1'b1, hold_pd);
    chk("dly.pcEn_at_pulse", 32'(pcEn), 32'd1);
    @(posedge clk); #1;
    chk("dly.pulse_end", 32'(delayEn), 32'd0);
    low_cnt = 0;
    for (int c = 0; c < 200 && pcEn == 1'b0; c++) begin
      low_cnt++;
      if (c % 4 == 1) begin
        sclkPosEdge = 1'b1; addr = 16'd10;
      end
      @(posedge clk); #1;
      sclkPosEdge = 1'b0;
      if (c % 4 == 1) chk_outs("dly.tick_ignored", 1'b1, hold_dc, 1'b0, hold_pd);
    end
    chk("dly.low_clks", 32'(low_cnt), 32'd48);
    chk("dly.pcEn_back", 32'(pcEn), 32'd1);
    tick(16'd10);
    chk_outs("dly.after", 1'b0, 1'b0, 1'b0, 8'hAE);

    // Reset mid-delay
    tick(16'd20);
    repeat (10) @(posedge clk);
    #2;
    chk("rst.pcEn_before", 32'(pcEn), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.pcEn", 32'(pcEn), 32'd1);
    chk_outs("rst.mid", 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk) reset = 1'b1;
    tick(16'd11);
    chk_outs("rst.next", 1'b0, 1'b1, 1'b0, 8'hA5);
    chk("rst.next.pcEn", 32'(pcEn), 32'd1);

    // Write and tick on the same clk decode the old word
    @(negedge clk);
    addr = 16'd30; dataIn = 10'h1BB; writeEnable = 1'b1; sclkPosEdge = 1'b1;
    @(posedge clk); #1;
    writeEnable = 1'b0; sclkPosEdge = 1'b0;
    chk_outs("wrtick", 1'b0, 1'b0, 1'b0, 8'hAA);
    chk("wrtick.newword", 32'(dataOut), 32'h1BB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
